// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer channel path: level width default,
// slew prescaler default and the slewer state encoding.
package rgb_mixer_pkg;

    localparam int LEVEL_WIDTH_DEF = 8;
    localparam int STEP_CYCLES_DEF = 256;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } slew_state_t;

    // Classify a level against its target: below -> RAMP_UP, above -> RAMP_DOWN.
    function automatic slew_state_t slew_state_for(input logic below, input logic above);
        slew_state_t s;
        case ({below, above})
            2'b10:   s = RAMP_UP;
            2'b01:   s = RAMP_DOWN;
            2'b00:   s = IDLE;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..PERIOD-1 and emits a one-cycle tick
// each time the count wraps. Shared with the debounce logic.
module tick_gen #(
    parameter int PERIOD = 256
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_r;
    logic          tick_r;

    // Prescaler counter with a registered wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            tick_r <= (count_r == LAST);
            if (count_r == LAST) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + ONE;
            end
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/level_slewer.sv
// Per-channel duty-level slewer. Moves the PWM level one LSB toward the
// sampled target per permitted step, and only on the PWM period boundary so
// no period ever sees a mid-period level change.
module level_slewer
    import rgb_mixer_pkg::*;
#(
    parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEVEL_WIDTH-1:0] target,
    input  logic                   bypass,
    input  logic                   period_start,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   settled,
    output logic                   ramping_up
);

    localparam logic [LEVEL_WIDTH-1:0] ONE = LEVEL_WIDTH'(1);

    logic                   tick_s;
    logic [LEVEL_WIDTH-1:0] level_r;
    logic [LEVEL_WIDTH-1:0] level_next_s;
    logic [LEVEL_WIDTH-1:0] target_r;
    logic [LEVEL_WIDTH-1:0] target_next_s;
    slew_state_t            state_r;
    slew_state_t            state_next_s;
    logic                   step_pending_r;
    logic                   pending_next_s;
    logic                   settled_r;
    logic                   ramping_up_r;

    tick_gen #(
        .PERIOD(STEP_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick_s)
    );

    // Next-state logic: everything holds between period boundaries except the
    // sticky step permission; a tick on the boundary cycle itself counts.
    always_comb begin
        level_next_s   = level_r;
        target_next_s  = target_r;
        state_next_s   = state_r;
        pending_next_s = step_pending_r | tick_s;
        if (period_start) begin
            target_next_s = target;
            if (bypass) begin
                level_next_s   = target;
                pending_next_s = 1'b0;
            end else if (level_r == target) begin
                pending_next_s = 1'b0;
            end else if (step_pending_r | tick_s) begin
                // Always step toward target, so no wrap past either rail.
                if (level_r < target) begin
                    level_next_s = level_r + ONE;
                end else begin
                    level_next_s = level_r - ONE;
                end
                pending_next_s = 1'b0;
            end else begin
                pending_next_s = 1'b0;
            end
            state_next_s = slew_state_for(level_next_s < target, level_next_s > target);
        end else begin
            level_next_s = level_r;
        end
    end

    // State, level and status registers; status tracks the state on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r        <= {LEVEL_WIDTH{1'b0}};
            target_r       <= {LEVEL_WIDTH{1'b0}};
            state_r        <= IDLE;
            step_pending_r <= 1'b0;
            settled_r      <= 1'b1;
            ramping_up_r   <= 1'b0;
        end else begin
            level_r        <= level_next_s;
            target_r       <= target_next_s;
            state_r        <= state_next_s;
            step_pending_r <= pending_next_s;
            settled_r      <= (state_next_s == IDLE);
            ramping_up_r   <= (state_next_s == RAMP_UP);
        end
    end

    assign level      = level_r;
    assign settled    = settled_r;
    assign ramping_up = ramping_up_r;

endmodule

// File: tb/tb_level_slewer.sv
// Scoreboard bench for level_slewer: instance A (STEP_CYCLES=4, period_start
// every 8 clocks) and instance B (STEP_CYCLES=16, period_start every 4 clocks).
module tb_level_slewer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b, bypass_a, bypass_b, ps_a, ps_b;
    logic [7:0] target_a, target_b, level_a, level_b;
    logic       settled_a, settled_b, ramp_a, ramp_b;

    int checks = 0;
    int errors = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic [9:0] exp_a, exp_b;

    level_slewer #(.LEVEL_WIDTH(8), .STEP_CYCLES(4)) u_a (
        .clk(clk), .reset(reset_a), .target(target_a), .bypass(bypass_a),
        .period_start(ps_a), .level(level_a), .settled(settled_a), .ramping_up(ramp_a)
    );

    level_slewer #(.LEVEL_WIDTH(8), .STEP_CYCLES(16)) u_b (
        .clk(clk), .reset(reset_b), .target(target_b), .bypass(bypass_b),
        .period_start(ps_b), .level(level_b), .settled(settled_b), .ramping_up(ramp_b)
    );

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor A: each period_start edge presents a new level; compare against the queue.
    always @(posedge clk) begin
        if (ps_a) begin
            #1;
            if (q_a.size() == 0) begin
                check("a_unexpected_output", 1, 0);
            end else begin
                exp_a = q_a.pop_front();
                check("a_level", int'(level_a), int'(exp_a[9:2]));
                check("a_settled", int'(settled_a), int'(exp_a[1]));
                check("a_ramping_up", int'(ramp_a), int'(exp_a[0]));
            end
        end
    end

    // Monitor B: same scheme for the slow-tick instance.
    always @(posedge clk) begin
        if (ps_b) begin
            #1;
            if (q_b.size() == 0) begin
                check("b_unexpected_output", 1, 0);
            end else begin
                exp_b = q_b.pop_front();
                check("b_level", int'(level_b), int'(exp_b[9:2]));
                check("b_settled", int'(settled_b), int'(exp_b[1]));
                check("b_ramping_up", int'(ramp_b), int'(exp_b[0]));
            end
        end
    end

    // One 8-clock PWM period on instance A: inputs carry noise between pulses,
    // the real target/bypass only on the pulse cycle.
    task automatic pa(input logic [7:0] tgt, input logic byp, input logic [7:0] noise,
                      input logic [7:0] e_level, input logic e_settled, input logic e_ramp);
        target_a = noise;
        bypass_a = (noise != tgt);
        ps_a     = 1'b0;
        repeat (7) @(negedge clk);
        target_a = tgt;
        bypass_a = byp;
        ps_a     = 1'b1;
        q_a.push_back({e_level, e_settled, e_ramp});
        @(negedge clk);
        ps_a = 1'b0;
    endtask

    initial begin
        reset_a  = 1'b1;
        reset_b  = 1'b1;
        ps_a     = 1'b0;
        ps_b     = 1'b0;
        bypass_a = 1'b0;
        bypass_b = 1'b0;
        target_a = 8'd0;
        target_b = 8'd255;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_level", int'(level_a), 0);
        check("reset_settled", int'(settled_a), 1);
        check("reset_ramping_up", int'(ramp_a), 0);
        check("reset_prescaler", int'(u_a.u_tick_gen.count_r), 0);
        reset_a = 1'b0;

        // Ramp 0 -> 3
        pa(8'd3, 1'b0, 8'd3, 8'd1, 1'b0, 1'b1);
        pa(8'd3, 1'b0, 8'd3, 8'd2, 1'b0, 1'b1);
        pa(8'd3, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0);
        pa(8'd3, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0);

        // Reversal: one step down, then back up to 5 without overshoot
        pa(8'd0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b0);
        pa(8'd5, 1'b0, 8'd5, 8'd3, 1'b0, 1'b1);
        pa(8'd5, 1'b0, 8'd5, 8'd4, 1'b0, 1'b1);
        pa(8'd5, 1'b0, 8'd5, 8'd5, 1'b1, 1'b0);
        pa(8'd5, 1'b0, 8'd5, 8'd5, 1'b1, 1'b0);

        // Top rail: jump to 250, no pulses for a while, then ramp to 255 and hold
        pa(8'd250, 1'b1, 8'd250, 8'd250, 1'b1, 1'b0);
        target_a = 8'd255;
        bypass_a = 1'b0;
        repeat (24) @(negedge clk);
        check("no_pulse_level_hold", int'(level_a), 250);
        check("no_pulse_settled_hold", int'(settled_a), 1);
        for (int i = 251; i <= 255; i++) begin
            pa(8'd255, 1'b0, 8'd255, 8'(i), (i == 255), (i != 255));
        end
        pa(8'd255, 1'b0, 8'd255, 8'd255, 1'b1, 1'b0);
        pa(8'd255, 1'b0, 8'd255, 8'd255, 1'b1, 1'b0);

        // Bypass from 0 to 200; target/bypass noise between pulses ignored
        pa(8'd0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0);
        pa(8'd200, 1'b1, 8'd200, 8'd200, 1'b1, 1'b0);
        pa(8'd200, 1'b0, 8'd17, 8'd200, 1'b1, 1'b0);
        pa(8'd200, 1'b0, 8'd0, 8'd200, 1'b1, 1'b0);

        // Reset mid-ramp at level 7, then restart from 0
        pa(8'd0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            pa(8'd10, 1'b0, 8'd10, 8'(i), 1'b0, 1'b1);
        end
        reset_a = 1'b1;
        @(negedge clk);
        check("midramp_reset_level", int'(level_a), 0);
        check("midramp_reset_settled", int'(settled_a), 1);
        check("midramp_reset_ramping_up", int'(ramp_a), 0);
        check("midramp_reset_prescaler", int'(u_a.u_tick_gen.count_r), 0);
        reset_a = 1'b0;
        pa(8'd10, 1'b0, 8'd10, 8'd1, 1'b0, 1'b1);
        pa(8'd10, 1'b0, 8'd10, 8'd2, 1'b0, 1'b1);

        // Instance B: tick every 16 clocks, period_start every 4; steps only on
        // every fourth pulse, which coincides with the tick.
        reset_b = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            ps_b = 1'b0;
            repeat (3) @(negedge clk);
            ps_b = 1'b1;
            q_b.push_back({8'(k / 4), 1'b0, 1'b1});
            @(negedge clk);
        end
        ps_b = 1'b0;

        repeat (4) @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
